cpu8_writeback: RTL and testbench

Writeback stage for the 8-bit CPU: accepts results from the ALU and from the memory-load path, arbitrates them onto the single register-file write port, and drives `enW`/`addrW`/`dataW`. Load results are buffered in a small queue, so a load returning while the ALU is writing back is never lost. A pending-write mask feeds the decode hazard logic, and an optional forwarding port exposes not-yet-written results.

---
 rtl/cpu8_pkg.sv | 16 +
 rtl/cpu8_wb_lq.sv | 81 ++++++++
 rtl/cpu8_writeback.sv | 133 +++++++++++++
 tb/tb_cpu8_writeback.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// rtl/cpu8_pkg.sv - shared types and widths for the cpu8 writeback stage
package cpu8_pkg;
    localparam int REG_AW   = 3;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } wb_state_t;
endpackage

// File: rtl/cpu8_wb_lq.sv
// rtl/cpu8_wb_lq.sv - load-result FIFO with count and age-ordered entry view
module cpu8_wb_lq
    import cpu8_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_req_t               push_req,
    input  logic                  pop,
    output wb_req_t               head,
    output logic [CW-1:0]         count,
    output logic [CW-1:0]         count_nxt,
    output logic                  full,
    output logic                  empty,
    output wb_req_t [DEPTH-1:0]   ent,
    output logic [DEPTH-1:0]      ent_valid
);
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Index 0 is the oldest entry, so later indices are younger.
    always_comb begin
        ent       = '0;
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent[i]       = mem_q[rd_ptr_q + PW'(i)];
            ent_valid[i] = (CW'(i) < count_q);
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
endmodule

// File: rtl/cpu8_writeback.sv
// rtl/cpu8_writeback.sv - arbitrates ALU and load results onto the register-file write port
// Optional forwarding lookup enabled by CPU8_WB_BYPASS_EN.
module cpu8_writeback
    import cpu8_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [REG_AW-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                enW,
    output logic [REG_AW-1:0]   addrW,
    output logic [DATA_W-1:0]   dataW,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef CPU8_WB_BYPASS_EN
    ,
    input  logic [REG_AW-1:0]   fwd_addr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data
`endif
);
    localparam int CW = $clog2(LQ_DEPTH) + 1;

    wb_state_t                 state_q, state_d;
    logic                      lq_push, lq_pop, lq_full, lq_empty;
    logic [CW-1:0]             lq_count, lq_count_nxt;
    wb_req_t                   lq_head, ld_req;
    wb_req_t [LQ_DEPTH-1:0]    lq_ent;
    logic [LQ_DEPTH-1:0]       lq_ent_valid;
    logic                      alu_take;
    logic                      wr_en_q, wr_en_d;
    logic [REG_AW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]         wr_data_q, wr_data_d;

    assign ld_req   = '{addr: ld_addr, data: ld_data};
    assign ld_ready = !lq_full;
    assign lq_push  = ld_valid && ld_ready;

    cpu8_wb_lq #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lq_push),
        .push_req  (ld_req),
        .pop       (lq_pop),
        .head      (lq_head),
        .count     (lq_count),
        .count_nxt (lq_count_nxt),
        .full      (lq_full),
        .empty     (lq_empty),
        .ent       (lq_ent),
        .ent_valid (lq_ent_valid)
    );

    // ALU has priority in NORMAL; DRAIN blocks it so the queue empties.
    assign alu_ready = (state_q == NORMAL);
    assign alu_take  = alu_valid && alu_ready;
    assign lq_pop    = !lq_empty && !alu_take;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (alu_take) begin
            wr_en_d   = 1'b1;
            wr_addr_d = alu_addr;
            wr_data_d = alu_data;
        end else if (lq_pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = lq_head.addr;
            wr_data_d = lq_head.data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:  if (lq_count_nxt == CW'(LQ_DEPTH)) state_d = DRAIN;
            DRAIN:   if (lq_count_nxt == '0) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= NORMAL;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign enW   = wr_en_q;
    assign addrW = wr_addr_q;
    assign dataW = wr_data_q;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_ent_valid[i]) busy_mask[lq_ent[i].addr] = 1'b1;
        end
        if (wr_en_q) busy_mask[wr_addr_q] = 1'b1;
    end

`ifdef CPU8_WB_BYPASS_EN
    // Output stage is oldest; queue entries scanned oldest-first so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (wr_en_q && wr_addr_q == fwd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data_q;
        end
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_ent_valid[i] && lq_ent[i].addr == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = lq_ent[i].data;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cpu8_writeback.sv
// tb/tb_cpu8_writeback.sv - scoreboard bench for cpu8_writeback with a queue-level reference model
module tb_cpu8_writeback;
    import cpu8_pkg::*;

    localparam int LQ = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_valid = 1'b0;
    logic       alu_ready;
    logic [2:0] alu_addr = '0;
    logic [7:0] alu_data = '0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [2:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       enW;
    logic [2:0] addrW;
    logic [7:0] dataW;
    logic [7:0] busy_mask;
    logic [2:0] fwd_addr = '0;
    logic       fwd_hit;
    logic [7:0] fwd_data;

    int vectors = 0;
    int miscompares = 0;

    wb_req_t mq[$];
    wb_req_t exp_q[$];
    bit      drain = 1'b0;
    wb_req_t last = '0;

    cpu8_writeback #(.LQ_DEPTH(LQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .enW       (enW),
        .addrW     (addrW),
        .dataW     (dataW),
        .busy_mask (busy_mask)
`ifdef CPU8_WB_BYPASS_EN
        ,
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: advances one clock edge using only the arbitration rules.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            drain = 1'b0;
        end else begin
            wb_req_t r;
            bit alu_acc, ld_acc;
            alu_acc = alu_valid && !drain;
            ld_acc  = ld_valid && (mq.size() < LQ);
            if (alu_acc) begin
                r.addr = alu_addr;
                r.data = alu_data;
                exp_q.push_back(r);
            end else if (mq.size() > 0) begin
                exp_q.push_back(mq.pop_front());
            end
            if (ld_acc) begin
                r.addr = ld_addr;
                r.data = ld_data;
                mq.push_back(r);
            end
            if (!drain && mq.size() == LQ) drain = 1'b1;
            else if (drain && mq.size() == 0) drain = 1'b0;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard between edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            last = '0;
            chk("rst_enW", 32'(enW), 32'd0);
            chk("rst_busy_mask", 32'(busy_mask), 32'd0);
            chk("rst_addrW", 32'(addrW), 32'd0);
            chk("rst_dataW", 32'(dataW), 32'd0);
            chk("rst_ld_ready", 32'(ld_ready), 32'd1);
            chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        end else begin
            bit wv;
            logic [7:0] mask;
            wv = (exp_q.size() > 0);
            if (wv) last = exp_q.pop_front();
            chk("enW", 32'(enW), 32'(wv));
            chk("addrW", 32'(addrW), 32'(last.addr));
            chk("dataW", 32'(dataW), 32'(last.data));
            mask = '0;
            foreach (mq[i]) mask[mq[i].addr] = 1'b1;
            if (wv) mask[last.addr] = 1'b1;
            chk("busy_mask", 32'(busy_mask), 32'(mask));
            chk("ld_ready", 32'(ld_ready), 32'(mq.size() < LQ));
            chk("alu_ready", 32'(alu_ready), 32'(!drain));
`ifdef CPU8_WB_BYPASS_EN
            begin
                bit hit;
                logic [7:0] d;
                hit = 1'b0;
                d   = '0;
                foreach (mq[i]) begin
                    if (mq[i].addr == fwd_addr) begin
                        hit = 1'b1;
                        d   = mq[i].data;
                    end
                end
                if (!hit && wv && last.addr == fwd_addr) begin
                    hit = 1'b1;
                    d   = last.data;
                end
                chk("fwd_hit", 32'(fwd_hit), 32'(hit));
                chk("fwd_data", 32'(fwd_data), 32'(d));
            end
`endif
        end
    end

    task automatic drive(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                         input bit lv, input logic [2:0] la, input logic [7:0] ld, input int fa);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ld;
        fwd_addr  = (fa < 0) ? 3'($urandom_range(0, 7)) : 3'(fa);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 99) < 55, 3'($urandom), 8'($urandom),
                  $urandom_range(0, 99) < 50, 3'($urandom), 8'($urandom), -1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1, 3'd3, 8'h5A, 0, 0, 0, -1);
        idle(3);

        drive(0, 0, 0, 1, 3'd1, 8'h11, -1);
        idle(4);

        drive(1, 3'($urandom), 8'($urandom), 1, 3'd1, 8'h11, -1);
        drive(1, 3'($urandom), 8'($urandom), 1, 3'd2, 8'h22, -1);
        for (int i = 0; i < 6; i++) drive(1, 3'($urandom), 8'($urandom), 0, 0, 0, -1);
        idle(4);

        for (int i = 0; i < 16; i++) drive(0, 0, 0, 1, 3'($urandom), 8'($urandom), -1);
        idle(4);

        drive(1, 3'd0, 8'h01, 1, 3'd4, 8'h10, -1);
        drive(1, 3'd0, 8'h02, 1, 3'd4, 8'h20, -1);
        drive(0, 0, 0, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 0, 0, 5);
        idle(4);

        rand_cycles(400);
        idle(4);

        drive(1, 3'd7, 8'hA1, 1, 3'd5, 8'h55, -1);
        drive(1, 3'd7, 8'hA2, 1, 3'd6, 8'h66, -1);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        rand_cycles(200);
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
